// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, NOP word,
// default widths and a saturating-increment helper for the optional perf counters.
package if_fetch_stage_pkg;

   localparam int PC_W_DEF   = 32;
   localparam int INST_W_DEF = 32;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (&value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Next-fetch-address mux. The address issued this cycle is also the value pc_q
// takes at the edge, so both outputs carry the same selection.
module if_pc_sel
   import if_fetch_stage_pkg::*;
#(
   parameter int               PC_W     = PC_W_DEF,
   parameter logic [0:PC_W-1]  RESET_PC = '0,
   parameter int unsigned      PC_INC   = 4
)
(
   input  logic              boot,
   input  logic              redirect,
   input  logic              stall,
   input  logic [0:PC_W-1]   pc_q,
   input  logic [0:15]       imm_addr,
   output logic [0:PC_W-1]   fetch_addr,
   output logic [0:PC_W-1]   pc_next
);

   always_comb begin
      fetch_addr = pc_q + PC_W'(PC_INC);
      if (boot) begin
         fetch_addr = RESET_PC;
      end else if (redirect) begin
         fetch_addr = PC_W'(imm_addr);
      end else if (stall) begin
         fetch_addr = pc_q;
      end
   end

   assign pc_next = fetch_addr;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register, stall hold and branch redirect.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int               PC_W     = PC_W_DEF,
   parameter int               INST_W   = INST_W_DEF,
   parameter logic [0:PC_W-1]  RESET_PC = '0,
   parameter int unsigned      PC_INC   = 4
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                ID_br_ctrl,
   input  logic [0:15]         ID_imm_addr,
   input  logic                br_hazard_stall,
   input  logic                hdu_stall,
   output logic [0:PC_W-1]     imem_addr,
   output logic                imem_en,
   input  logic [0:INST_W-1]   imem_dout,
   output logic [0:INST_W-1]   IFID_inst,
   output logic [0:PC_W-1]     IFID_pc,
   output logic                IFID_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [0:31]         perf_fetch_cnt,
   output logic [0:31]         perf_stall_cnt,
   output logic [0:31]         perf_flush_cnt
`endif
);

   logic                stall;
   logic                redirect;
   logic [1:0]          state;
   logic [1:0]          state_next;
   logic [0:PC_W-1]     pc_q;
   logic [0:PC_W-1]     pc_next;
   logic [0:INST_W-1]   hold_inst;
   logic [0:INST_W-1]   load_inst;
   logic                boot;
   logic                active;
   logic                squash;
   logic                load;

   assign stall    = br_hazard_stall | hdu_stall;
   assign redirect = ID_br_ctrl & ~stall;

   assign boot   = (state == ST_BOOT);
   assign active = (state == ST_RUN) | (state == ST_STALL);
   assign squash = active & redirect;
   assign load   = active & ~stall & ~redirect;
   // Once stalled, imem output is no longer valid; replay the captured word.
   assign load_inst = (state == ST_STALL) ? hold_inst : imem_dout;

   assign imem_en = boot | ~stall;

   if_pc_sel #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC),
      .PC_INC   (PC_INC)
   ) u_pc_sel (
      .boot       (boot),
      .redirect   (redirect),
      .stall      (stall),
      .pc_q       (pc_q),
      .imm_addr   (ID_imm_addr),
      .fetch_addr (imem_addr),
      .pc_next    (pc_next)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT:  state_next = ST_RUN;
         ST_RUN:   state_next = (stall) ? ST_STALL : ST_RUN;
         ST_STALL: state_next = (stall) ? ST_STALL : ST_RUN;
         default:  state_next = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_BOOT;
         pc_q       <= RESET_PC;
         hold_inst  <= '0;
         IFID_inst  <= '0;
         IFID_pc    <= '0;
         IFID_valid <= 1'b0;
      end else begin
         state <= state_next;
         if (boot | squash | load) begin
            pc_q <= pc_next;
         end
         if ((state == ST_RUN) && stall) begin
            hold_inst <= imem_dout;
         end
         if (squash) begin
            IFID_inst  <= INST_W'(NOP_INST);
            IFID_pc    <= '0;
            IFID_valid <= 1'b0;
         end else if (load) begin
            IFID_inst  <= load_inst;
            IFID_pc    <= pc_q;
            IFID_valid <= 1'b1;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (load) begin
            perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
         end
         if (active & stall) begin
            perf_stall_cnt <= sat_inc(perf_stall_cnt);
         end
         if (squash) begin
            perf_flush_cnt <= sat_inc(perf_flush_cnt);
         end
      end
   end
`endif

endmodule
